// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the FSM encoding, print addresses and the latency bound.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [31:0] PRINT_ADDR_0 = 32'h8000_0000;
    localparam logic [31:0] PRINT_ADDR_1 = 32'h8000_0064;
    localparam int          MEM_LAT_MAX  = 4;

    function automatic logic is_print_addr(input logic [31:0] addr);
        return (addr == PRINT_ADDR_0) || (addr == PRINT_ADDR_1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
// Purely combinational, no backpressure of its own.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end else if (req[1]) begin
            gnt_id = 1'b1;
        end
        if (req != 2'b00) begin
            gnt = 2'b01 << gnt_id;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for the single data-memory/MMIO port with a print-address display snoop.
// Latency: accept at T, mem_en at T+1, response at T+1+MEM_LAT; one transaction per MEM_LAT+2 cycles.
// Backpressure: req_ready only in IDLE; responses are never stalled.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_wen,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        mem_en,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        disp_we,
    output logic [31:0] disp_data
);

    // WAIT lasts MEM_LAT-1 cycles; the 2-bit counter covers the full legal range 1..4.
    localparam logic [1:0] WAIT_LOAD = 2'(MEM_LAT - 1);

    arb_state_t  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        req_wen_q, req_wen_d;
    logic        req_id_q, req_id_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic        mem_en_q, mem_en_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        disp_we_q, disp_we_d;
    logic [31:0] disp_data_q, disp_data_d;

    logic [1:0]  gnt;
    logic        gnt_id;
    logic        accept;
    logic        sel_wen;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .gnt_id     (gnt_id)
    );

    assign accept    = (state_q == IDLE) && (req_valid != 2'b00);
    assign req_ready = accept ? gnt : 2'b00;
    assign sel_wen   = req_wen[gnt_id];
    assign sel_addr  = gnt_id ? req_addr1  : req_addr0;
    assign sel_wdata = gnt_id ? req_wdata1 : req_wdata0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        req_wen_d    = req_wen_q;
        req_id_d     = req_id_q;
        // addr/wdata double as the memory output register, so they drop to 0 outside ISSUE
        req_addr_d   = 32'h0;
        req_wdata_d  = 32'h0;
        mem_en_d     = 1'b0;
        rsp_valid_d  = 2'b00;
        rsp_rdata_d  = 32'h0;
        disp_we_d    = 1'b0;
        disp_data_d  = disp_data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = ISSUE;
                    last_grant_d = gnt_id;
                    req_id_d     = gnt_id;
                    req_wen_d    = sel_wen;
                    req_addr_d   = sel_addr;
                    req_wdata_d  = sel_wdata;
                    mem_en_d     = 1'b1;
                    if (sel_wen && is_print_addr(sel_addr)) begin
                        disp_we_d   = 1'b1;
                        disp_data_d = sel_wdata;
                    end
                end
            end
            ISSUE: begin
                if (MEM_LAT > 1) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 2'b01 << req_id_q;
                    rsp_rdata_d = req_wen_q ? 32'h0 : mem_rdata;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd1) begin
                    state_d     = RESP;
                    cnt_d       = 2'd0;
                    rsp_valid_d = 2'b01 << req_id_q;
                    rsp_rdata_d = req_wen_q ? 32'h0 : mem_rdata;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            last_grant_q <= 1'b1;
            req_wen_q    <= 1'b0;
            req_id_q     <= 1'b0;
            req_addr_q   <= 32'h0;
            req_wdata_q  <= 32'h0;
            mem_en_q     <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= 32'h0;
            disp_we_q    <= 1'b0;
            disp_data_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            req_wen_q    <= req_wen_d;
            req_id_q     <= req_id_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            mem_en_q     <= mem_en_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            disp_we_q    <= disp_we_d;
            disp_data_q  <= disp_data_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_wen   = mem_en_q & req_wen_q;
    assign mem_addr  = req_addr_q;
    assign mem_wdata = req_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign disp_we   = disp_we_q;
    assign disp_data = disp_data_q;

endmodule
